// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: repeat FSM state
// encodings and small elaboration-time helpers for counter sizing.
package key_conditioner_pkg;

    // Repeat FSM states; 2'b11 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } state_e;

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_debounce_filter.sv
// Two-flop synchroniser plus consecutive-cycle debounce counter for one
// active-low raw button input. Produces the debounced pressed level and
// registered single-cycle rise/fall pulses coincident with its flips.
module debounce_filter
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int                 DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]      LIMIT_M1 = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]      ONE      = DW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] cnt_q,    cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q,   rise_d;
    logic          fall_q,   fall_d;
    logic          level_s;
    logic          mismatch_s;

    // Two-flop synchroniser; resets to the released (high) raw level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

    assign level_s    = ~sync2_q;
    assign mismatch_s = (level_s != stable_q);

    // Count consecutive mismatching cycles; flip the level on the Nth one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (!mismatch_s) begin
            cnt_d = {DW{1'b0}};
        end else if (cnt_q >= LIMIT_M1) begin
            cnt_d    = {DW{1'b0}};
            stable_d = level_s;
            rise_d   = level_s;
            fall_d   = ~level_s;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Debounce state and edge pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= {DW{1'b0}};
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: debounces one active-low key and produces a
// registered pressed level, press pulses with auto-repeat while held, and
// a release pulse. One instance per board key.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 5_000_000,
    parameter bit REPEAT_ENABLE        = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            RW          = cnt_width(max_int(REPEAT_DELAY_CYCLES,
                                                              REPEAT_PERIOD_CYCLES));
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic [RW-1:0] ONE         = RW'(1);
    localparam logic [RW-1:0] ZERO        = {RW{1'b0}};

    logic          stable_s;
    logic          rise_s;
    logic          fall_s;
    state_e        state_q,   state_d;
    logic [RW-1:0] cnt_q,     cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .raw_n  (key_n),
        .stable (stable_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Repeat FSM next state, shared down-counter and output pulse decode.
    // A release always takes priority over a repeat expiring that cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = stable_s;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    release_d = 1'b1;
                    cnt_d     = ZERO;
                end else if (rise_s) begin
                    press_d = 1'b1;
                    cnt_d   = DELAY_LOAD;
                    state_d = ST_DELAY;
                end else begin
                    cnt_d = ZERO;
                end
            end
            ST_DELAY: begin
                if (fall_s) begin
                    release_d = 1'b1;
                    cnt_d     = ZERO;
                    state_d   = ST_IDLE;
                end else if (!REPEAT_ENABLE) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == ZERO) begin
                    press_d = 1'b1;
                    cnt_d   = PERIOD_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    release_d = 1'b1;
                    cnt_d     = ZERO;
                    state_d   = ST_IDLE;
                end else if (cnt_q == ZERO) begin
                    press_d = 1'b1;
                    cnt_d   = PERIOD_LOAD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = ZERO;
                pressed_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= ZERO;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, DELAY=10, PERIOD=3.
// Two instances share clock, reset and key: one with auto-repeat, one without.
// Edge k is the k-th rising clock edge after reset is released; key_n for
// edge k is driven before that edge and outputs are sampled 1 time unit after.
module tb_key_conditioner;
    import key_conditioner_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic key_n = 1'b1;
    logic pr_r, pp_r, rp_r;
    logic pr_n, pp_n, rp_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic key_n;
        logic exp_pressed;
        logic exp_press;
        logic exp_release;
        logic exp_press_nr;
    } vec_t;

    vec_t tab [64];
    int   n_vec;
    int   exp_count;

    always #5 clock = ~clock;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
        .REPEAT_PERIOD_CYCLES(3), .REPEAT_ENABLE(1'b1)
    ) dut_r (
        .clock(clock), .reset(reset), .key_n(key_n),
        .pressed(pr_r), .press_pulse(pp_r), .release_pulse(rp_r)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
        .REPEAT_PERIOD_CYCLES(3), .REPEAT_ENABLE(1'b0)
    ) dut_n (
        .clock(clock), .reset(reset), .key_n(key_n),
        .pressed(pr_n), .press_pulse(pp_n), .release_pulse(rp_n)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Build a table: key pressed for edges < hold; first press pulse at
    // edge 'first'; repeats at first+10, +13, ...; release pulse at hold+6
    // (suppressing any repeat that would land there).
    task automatic fill(input int n, input int hold, input int first);
        int rel;
        rel       = hold + 6;
        n_vec     = n;
        exp_count = 0;
        for (int k = 0; k < n; k++) begin
            tab[k].key_n        = (k < hold) ? 1'b0 : 1'b1;
            tab[k].exp_pressed  = (k >= first) && (k < rel);
            tab[k].exp_press    = (k == first) ||
                                  ((k >= first + 10) && (k < rel) &&
                                   (((k - first - 10) % 3) == 0));
            tab[k].exp_release  = (k == rel);
            tab[k].exp_press_nr = (k == first);
            if (tab[k].exp_press) exp_count++;
        end
    endtask

    task automatic run(input string name);
        int cnt_r;
        int cnt_n;
        cnt_r = 0;
        cnt_n = 0;
        for (int k = 0; k < n_vec; k++) begin
            key_n = tab[k].key_n;
            @(posedge clock);
            #1;
            chk($sformatf("%s pressed@%0d", name, k), pr_r, tab[k].exp_pressed);
            chk($sformatf("%s press@%0d", name, k), pp_r, tab[k].exp_press);
            chk($sformatf("%s release@%0d", name, k), rp_r, tab[k].exp_release);
            chk($sformatf("%s nr_pressed@%0d", name, k), pr_n, tab[k].exp_pressed);
            chk($sformatf("%s nr_press@%0d", name, k), pp_n, tab[k].exp_press_nr);
            chk($sformatf("%s nr_release@%0d", name, k), rp_n, tab[k].exp_release);
            if (pp_r) cnt_r++;
            if (pp_n) cnt_n++;
        end
        chk($sformatf("%s press_count", name), cnt_r, exp_count);
        chk($sformatf("%s nr_press_count", name), cnt_n,
            (exp_count > 0) ? 1 : 0);
    endtask

    task automatic do_reset(input logic key);
        reset = 1'b0;
        key_n = key;
        @(posedge clock);
        #1;
        chk("reset pressed", pr_r, 0);
        chk("reset press", pp_r, 0);
        chk("reset release", rp_r, 0);
        chk("reset nr_pressed", pr_n, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // 1: key held through reset, press recognised 6 edges after release
        do_reset(1'b0);
        fill(10, 100, 6);
        run("reset_held");

        // 2: bouncing press, steady from edge 8, single pulse at edge 14
        do_reset(1'b1);
        fill(20, 100, 14);
        tab[3].key_n = 1'b1;
        tab[7].key_n = 1'b1;
        run("bounce");

        // 3: clean 8-cycle press
        do_reset(1'b1);
        fill(20, 8, 6);
        run("clean");

        // 4a: long hold, 12 press pulses then one release
        do_reset(1'b1);
        fill(52, 42, 6);
        run("hold42");

        // 4b: 40-cycle hold, release lands on a repeat and wins
        do_reset(1'b1);
        fill(50, 40, 6);
        run("hold40");

        // 5: release while still in the repeat delay
        do_reset(1'b1);
        fill(16, 5, 6);
        run("rel_delay");
        chk("rel_delay fsm_idle", 32'(dut_r.state_q), 32'(ST_IDLE));

        // 6: asynchronous reset mid-repeat, then key still held
        do_reset(1'b1);
        for (int k = 0; k <= 16; k++) begin
            key_n = 1'b0;
            @(posedge clock);
            #1;
        end
        chk("mid_repeat press@16", pp_r, 1);
        chk("mid_repeat pressed@16", pr_r, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset pressed", pr_r, 0);
        chk("async_reset press", pp_r, 0);
        chk("async_reset release", rp_r, 0);
        chk("async_reset nr_pressed", pr_n, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        fill(10, 100, 6);
        run("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
